// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding, lamp indices and default timing for the walk sequencer
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_IN   = 3'd2,
    WALK        = 3'd3,
    WALK_FLASH  = 3'd4,
    ALLRED_OUT  = 3'd5
  } state_e;

  localparam int LAMP_GREEN  = 0;
  localparam int LAMP_YELLOW = 1;
  localparam int LAMP_RED    = 2;
  localparam int LAMP_WALK   = 3;
  localparam int LAMP_W      = 4;

  localparam int DEF_GREEN_MIN = 10;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 1;
  localparam int DEF_WALK_T    = 8;
  localparam int DEF_FLASH_T   = 4;
  localparam int DEF_CNT_W     = 8;

  // Red accompanies every pedestrian-facing state, so walk can never show without it.
  function automatic logic [LAMP_W-1:0] lamp_decode(input state_e s, input logic flash);
    logic [LAMP_W-1:0] l;
    l = '0;
    case (s)
      MAIN_GREEN:  l[LAMP_GREEN] = 1'b1;
      MAIN_YELLOW: l[LAMP_YELLOW] = 1'b1;
      WALK: begin
        l[LAMP_RED]  = 1'b1;
        l[LAMP_WALK] = 1'b1;
      end
      WALK_FLASH: begin
        l[LAMP_RED]  = 1'b1;
        l[LAMP_WALK] = flash;
      end
      default:     l[LAMP_RED] = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - tick-enabled counter with clear, optional saturation and terminal-count flag
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         sat,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !(sat && (count_q == term))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == term);

endmodule

// File: rtl/walk_sequencer.sv
// rtl/walk_sequencer.sv - main-road / pedestrian phase sequencer with request-clear handshake
// Optional walk countdown output is built when WALK_COUNTDOWN_EN is defined.
module walk_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int WALK_T    = DEF_WALK_T,
  parameter int FLASH_T   = DEF_FLASH_T,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic             tick_en,
  input  logic             walkRegister_status,
  output logic             walkRegister_reset,
  output logic             main_green,
  output logic             main_yellow,
  output logic             main_red,
  output logic             walk_lamp,
  output logic [CNT_W-1:0] walk_countdown
);

  localparam logic [CNT_W-1:0] GREEN_TERM  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_TERM = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_TERM = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_TERM   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] FLASH_TERM  = CNT_W'(FLASH_T - 1);

  state_e            state_q, state_d;
  logic              flash_q, flash_d;
  logic [LAMP_W-1:0] lamps_q, lamps_d;
  logic              clr_pulse_q, clr_pulse_d;
  logic [CNT_W-1:0]  term;
  logic              tmr_tc;
  logic              tmr_clr;
  logic              expire;
  logic              walk_entry;

  tick_timer #(.W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (sys_reset),
    .en   (tick_en),
    .clr  (tmr_clr),
    .sat  (state_q == MAIN_GREEN),
    .term (term),
    .tc   (tmr_tc)
  );

  always_comb begin
    case (state_q)
      MAIN_GREEN:  term = GREEN_TERM;
      MAIN_YELLOW: term = YELLOW_TERM;
      WALK:        term = WALK_TERM;
      WALK_FLASH:  term = FLASH_TERM;
      default:     term = ALLRED_TERM;
    endcase
  end

  always_comb begin
    expire  = tick_en && tmr_tc;
    state_d = state_q;
    if (expire) begin
      case (state_q)
        MAIN_GREEN:  if (walkRegister_status) state_d = MAIN_YELLOW;
        MAIN_YELLOW: state_d = ALLRED_IN;
        ALLRED_IN:   state_d = WALK;
        WALK:        state_d = WALK_FLASH;
        WALK_FLASH:  state_d = ALLRED_OUT;
        default:     state_d = MAIN_GREEN;
      endcase
    end
    tmr_clr    = (state_d != state_q);
    walk_entry = (state_d == WALK) && (state_q != WALK);

    flash_d = 1'b0;
    if (state_d == WALK_FLASH) begin
      if (state_q != WALK_FLASH) flash_d = 1'b1;
      else if (tick_en)          flash_d = ~flash_q;
      else                       flash_d = flash_q;
    end

    lamps_d     = lamp_decode(state_d, flash_d);
    clr_pulse_d = walk_entry;
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q     <= MAIN_GREEN;
      flash_q     <= 1'b0;
      lamps_q     <= lamp_decode(MAIN_GREEN, 1'b0);
      clr_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flash_q     <= flash_d;
      lamps_q     <= lamps_d;
      clr_pulse_q <= clr_pulse_d;
    end
  end

`ifdef WALK_COUNTDOWN_EN
  logic [CNT_W-1:0] cd_q, cd_d;

  // Loaded on walk entry; the tick that moves WALK into WALK_FLASH also counts down.
  always_comb begin
    cd_d = '0;
    if (walk_entry) begin
      cd_d = CNT_W'(WALK_T + FLASH_T);
    end else if ((state_d == WALK) || (state_d == WALK_FLASH)) begin
      cd_d = tick_en ? (cd_q - 1'b1) : cd_q;
    end
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      cd_q <= '0;
    end else begin
      cd_q <= cd_d;
    end
  end

  assign walk_countdown = cd_q;
`else
  assign walk_countdown = '0;
`endif

  assign walkRegister_reset = clr_pulse_q;
  assign main_green         = lamps_q[LAMP_GREEN];
  assign main_yellow        = lamps_q[LAMP_YELLOW];
  assign main_red           = lamps_q[LAMP_RED];
  assign walk_lamp          = lamps_q[LAMP_WALK];

endmodule

// File: tb/tb_walk_sequencer.sv
// tb/tb_walk_sequencer.sv - segment table plus per-cycle scoreboard bench for walk_sequencer
module tb_walk_sequencer;

  localparam int G = 10, Y = 3, A = 1, W = 8, F = 4;
  localparam int P_WALK = Y + A;
  localparam int P_FLASH = Y + A + W;
  localparam int P_OUT = Y + A + W + F;
  localparam int P_END = P_OUT + A - 1;
`ifdef WALK_COUNTDOWN_EN
  localparam int CDE = 1;
`else
  localparam int CDE = 0;
`endif

  logic       clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       tick_en = 1'b0;
  logic       walkRegister_status = 1'b0;
  logic       walkRegister_reset;
  logic       main_green, main_yellow, main_red, walk_lamp;
  logic [7:0] walk_countdown;

  walk_sequencer dut (
    .clk                 (clk),
    .sys_reset           (sys_reset),
    .tick_en             (tick_en),
    .walkRegister_status (walkRegister_status),
    .walkRegister_reset  (walkRegister_reset),
    .main_green          (main_green),
    .main_yellow         (main_yellow),
    .main_red            (main_red),
    .walk_lamp           (walk_lamp),
    .walk_countdown      (walk_countdown)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lamps;
    bit         pulse;
    int         cd;
  } exp_t;

  typedef struct {
    int         ticks;
    bit         req;
    int         gap;
    logic [3:0] exp_lamps;
    int         exp_pulses;
    int         exp_cd;
  } seg_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pulse_cnt;

  // Model: m_g is green-phase tick count, m_p is ticks since yellow began.
  bit m_in = 0;
  int m_g = 0;
  int m_p = 0;

  function automatic exp_t model_out(input bit in_c, input int p, input bit pulse);
    exp_t e;
    e.pulse = pulse;
    e.cd = 0;
    if (!in_c)               e.lamps = 4'b0001;
    else if (p < Y)          e.lamps = 4'b0010;
    else if (p < P_WALK)     e.lamps = 4'b0100;
    else if (p < P_FLASH)    e.lamps = 4'b1100;
    else if (p < P_OUT)      e.lamps = ((p - P_FLASH) % 2 == 0) ? 4'b1100 : 4'b0100;
    else                     e.lamps = 4'b0100;
    if (in_c && p >= P_WALK && p < P_OUT) e.cd = CDE * (P_OUT - p);
    return e;
  endfunction

  function automatic logic [3:0] dut_lamps();
    return {walk_lamp, main_red, main_yellow, main_green};
  endfunction

  task automatic cyc(input bit t, input bit r);
    exp_t e;
    bit pulse;
    tick_en = t;
    walkRegister_status = r;
    pulse = 0;
    if (t) begin
      if (!m_in) begin
        if (m_g == G - 1 && r) begin
          m_in = 1; m_p = 0;
        end else if (m_g < G - 1) begin
          m_g++;
        end
      end else if (m_p == P_END) begin
        m_in = 0; m_g = 0;
      end else begin
        m_p++;
        if (m_p == P_WALK) pulse = 1;
      end
    end
    sb.push_back(model_out(m_in, m_p, pulse));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    pulse_cnt += int'(walkRegister_reset);
    if (dut_lamps() !== e.lamps || walkRegister_reset !== e.pulse || int'(walk_countdown) != e.cd) begin
      n_err++;
      $display("FAIL cycle t=%0t: lamps=%b pulse=%b cd=%0d, required lamps=%b pulse=%b cd=%0d",
               $time, dut_lamps(), walkRegister_reset, walk_countdown, e.lamps, e.pulse, e.cd);
    end
  endtask

  task automatic check_now(input string name, input logic [3:0] lamps, input bit pulse, input int cd);
    n_vec++;
    if (dut_lamps() !== lamps || walkRegister_reset !== pulse || int'(walk_countdown) != cd) begin
      n_err++;
      $display("FAIL %s: lamps=%b pulse=%b cd=%0d, required lamps=%b pulse=%b cd=%0d",
               name, dut_lamps(), walkRegister_reset, walk_countdown, lamps, pulse, cd);
    end
  endtask

  seg_t segs[12];

  initial begin
    segs[0]  = '{50, 1'b0, 1, 4'b0001, 0, 0};
    segs[1]  = '{1,  1'b1, 0, 4'b0010, 0, 0};
    segs[2]  = '{4,  1'b1, 0, 4'b1100, 1, 12 * CDE};
    segs[3]  = '{8,  1'b0, 1, 4'b1100, 0, 4 * CDE};
    segs[4]  = '{1,  1'b0, 0, 4'b0100, 0, 3 * CDE};
    segs[5]  = '{3,  1'b0, 0, 4'b0100, 0, 0};
    segs[6]  = '{1,  1'b0, 0, 4'b0001, 0, 0};
    segs[7]  = '{10, 1'b1, 0, 4'b0010, 0, 0};
    segs[8]  = '{4,  1'b1, 0, 4'b1100, 1, 12 * CDE};
    segs[9]  = '{13, 1'b1, 0, 4'b0001, 0, 0};
    segs[10] = '{9,  1'b1, 0, 4'b0001, 0, 0};
    segs[11] = '{1,  1'b1, 0, 4'b0010, 0, 0};

    #12;
    check_now("reset_state", 4'b0001, 1'b0, 0);
    @(negedge clk);
    sys_reset = 1'b0;

    for (int s = 0; s < 12; s++) begin
      pulse_cnt = 0;
      for (int k = 0; k < segs[s].ticks; k++) begin
        cyc(1'b1, segs[s].req);
        for (int g = 0; g < segs[s].gap; g++) cyc(1'b0, segs[s].req);
      end
      n_vec++;
      if (dut_lamps() !== segs[s].exp_lamps || pulse_cnt != segs[s].exp_pulses ||
          int'(walk_countdown) != segs[s].exp_cd) begin
        n_err++;
        $display("FAIL seg%0d: lamps=%b pulses=%0d cd=%0d, required lamps=%b pulses=%0d cd=%0d",
                 s, dut_lamps(), pulse_cnt, walk_countdown,
                 segs[s].exp_lamps, segs[s].exp_pulses, segs[s].exp_cd);
      end
    end

    // Into WALK again, then an asynchronous reset between clock edges.
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1);
    check_now("walk_before_reset", 4'b1100, 1'b1, 12 * CDE);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    tick_en = 1'b0;
    @(posedge clk);
    #2;
    sys_reset = 1'b1;
    #1;
    check_now("async_reset_midwalk", 4'b0001, 1'b0, 0);
    m_in = 0; m_g = 0; m_p = 0;
    @(negedge clk);
    sys_reset = 1'b0;
    pulse_cnt = 0;
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0);
    n_vec++;
    if (pulse_cnt != 0) begin
      n_err++;
      $display("FAIL no_pulse_after_reset: pulses=%0d, required 0", pulse_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
